count_wrap_tracker: RTL
=======================

COUNT_WRAP_TRACKER -- requirements
Module: count_wrap_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the observed counter value.
REQ-002 SHALL have parameter WRAP_W, default 8: width of each wrap tally.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port cnt_in  input  CNT_W: count value from the upstream up/down counter.
REQ-006 SHALL have port m_in  input  1: counter direction (0 = up, 1 = down).
REQ-007 SHALL have port cnt_vld  input  1: cnt_in is meaningful this cycle.
REQ-008 SHALL have port clr  input  1: synchronous clear of tallies, error flag and state.
REQ-009 SHALL have port wrap_up  output  1: one-cycle pulse for an up-wrap, all-ones to zero.
REQ-010 SHALL have port wrap_dn  output  1: one-cycle pulse for a down-wrap, zero to all-ones.
REQ-011 SHALL have port up_wraps  output  WRAP_W: saturating up-wrap tally.
REQ-012 SHALL have port dn_wraps  output  WRAP_W: saturating down-wrap tally.
REQ-013 SHALL have port step_err  output  1: sticky illegal-step flag.

Function
REQ-014 SHALL implement FSM states IDLE (no previous sample), TRACK (prev_q held) and ERR (step error latched).
REQ-015 State transitions SHALL be: IDLE with cnt_vld=1 loads prev_q<=cnt_in and goes to TRACK; TRACK with cnt_vld=1 compares, then updates prev_q; cnt_vld=0 in IDLE or TRACK goes to IDLE, emits no events and discards prev_q.
REQ-016 In TRACK, a step SHALL be legal if cnt_in==prev_q (hold), or cnt_in==prev_q+1 mod 2^CNT_W with m_in=0, or cnt_in==prev_q-1 mod 2^CNT_W with m_in=1.
REQ-017 Up-wrap SHALL be defined as prev_q all-ones, cnt_in==0 and m_in=0; down-wrap SHALL be defined as prev_q==0, cnt_in all-ones and m_in=1.
REQ-018 wrap_up and wrap_dn SHALL be registered, asserting on the cycle after the sampling edge (latency 1 cycle), for exactly one cycle per event.
REQ-019 On each wrap event, the matching tally SHALL increment by 1 on the same edge that asserts the pulse, saturating at 2^WRAP_W-1.
REQ-020 A saturated tally SHALL hold its value while the wrap pulse still asserts.
REQ-021 Any non-legal step in TRACK (including a wrap with mismatched m_in) SHALL produce no wrap pulse and no tally change.
REQ-022 clr SHALL have priority over every other input: next state IDLE, both tallies 0, step_err 0, no pulse.
REQ-023 A wrap detected on the same edge as clr SHALL be dropped.
REQ-024 In ERR, the block SHALL perform no wrap detection, hold both tallies and keep step_err=1, regardless of cnt_vld.
REQ-025 ERR SHALL be left only via clr or rst.

Reset
REQ-026 rst low SHALL asynchronously force state IDLE, prev_q=0, wrap_up=0, wrap_dn=0, up_wraps=0, dn_wraps=0 and step_err=0.
REQ-027 rst asserted mid-operation SHALL discard any pending pulse.
REQ-028 After rst deasserts, the first cnt_vld=1 sample SHALL only load prev_q; no event SHALL be possible before the second valid sample.

Configuration
REQ-029 Macro COUNT_WRAP_TRACKER_STEP_CHECK_EN, when defined, SHALL make an illegal step in TRACK move the FSM to ERR and set step_err=1 on the same edge.
REQ-030 With COUNT_WRAP_TRACKER_STEP_CHECK_EN undefined, the ERR state SHALL be absent, step_err SHALL be tied 0, and an illegal step SHALL only update prev_q and remain in TRACK.

Structure
REQ-031 Package count_wrap_pkg SHALL hold the FSM state enum (IDLE, TRACK, ERR) and the default CNT_W and WRAP_W constants.
REQ-032 A sub-module sat_ctr (WRAP_W-bit saturating incrementer with synchronous clear and async active-low reset) SHALL be instantiated twice, once per tally.

Verification
REQ-033 Bench SHALL drive cnt_vld=1, m_in=0 and cnt_in 13,14,15,0,1, and SHALL check wrap_up high only the cycle after the 0 sample, with up_wraps=1.
REQ-034 Bench SHALL drive m_in=1 and cnt_in 2,1,0,15,14, and SHALL check wrap_dn pulses once, dn_wraps=1 and wrap_up stays 0.
REQ-035 Bench SHALL drive cnt_in 5,9 with STEP_CHECK_EN defined, and SHALL check step_err=1 after the edge; a following 15,0 sequence SHALL give no wrap_up; clr SHALL return step_err=0 and state IDLE.
REQ-036 Bench SHALL preload up_wraps to 255 via 255 up-wraps, then apply a 256th, and SHALL check wrap_up pulses and up_wraps stays 255.
REQ-037 Bench SHALL drive 15 then drop cnt_vld for 1 cycle then drive 0, and SHALL check no wrap_up (prev_q discarded).
REQ-038 Bench SHALL assert rst low mid-cycle during a 15 to 0 transition, and SHALL check all outputs 0 immediately and no pulse after release.

Source files
------------

// File: rtl/count_wrap_pkg.sv
// Shared types and default widths for the count wrap tracker.
package count_wrap_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned WRAP_W_DEF = 8;

  // ERR is only ever entered when step checking is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_ctr.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Clear wins; an increment at all-ones leaves the value pinned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_wrap_tracker.sv
// Watches an up/down counter stream and reports wrap-arounds with one-cycle
// pulses and saturating tallies.
// Optional macro COUNT_WRAP_TRACKER_STEP_CHECK_EN: an illegal step locks the
// block in ERR with step_err set until clr or rst.
module count_wrap_tracker
  import count_wrap_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              m_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] up_wraps,
  output logic [WRAP_W-1:0] dn_wraps,
  output logic              step_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             wrap_up_q, wrap_dn_q;
  logic             in_track;
  logic             up_evt, dn_evt;

  // A comparison happens only with a held sample, valid input and no clear.
  assign in_track = (state_q == TRACK) && cnt_vld && !clr;

  // A wrap pattern is always a legal +1/-1 step, so no extra legality term.
  assign up_evt = in_track && !m_in && (prev_q == '1) && (cnt_in == '0);
  assign dn_evt = in_track &&  m_in && (prev_q == '0) && (cnt_in == '1);

`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
  logic [CNT_W-1:0] prev_inc, prev_dec;
  logic             step_ok;
  logic             err_q, err_d;

  assign prev_inc = prev_q + CNT_W'(1);
  assign prev_dec = prev_q - CNT_W'(1);
  assign step_ok  = (cnt_in == prev_q) ||
                    (!m_in && (cnt_in == prev_inc)) ||
                    ( m_in && (cnt_in == prev_dec));
`endif

  // Next-state logic for the FSM, the held sample and the error flag.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
    err_d   = err_q;
`endif
    if (clr) begin
      state_d = IDLE;
      prev_d  = '0;
`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_vld) begin
            state_d = TRACK;
            prev_d  = cnt_in;
          end
        end
        TRACK: begin
          if (!cnt_vld) begin
            // Losing a valid sample breaks continuity: forget it.
            state_d = IDLE;
            prev_d  = '0;
          end else begin
`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
            if (!step_ok) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              prev_d = cnt_in;
            end
`else
            prev_d = cnt_in;
`endif
          end
        end
`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
        ERR: begin
          state_d = ERR;
        end
`endif
        default: begin
          state_d = IDLE;
          prev_d  = '0;
        end
      endcase
    end
  end

  // State, held sample and registered wrap pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      wrap_up_q <= up_evt;
      wrap_dn_q <= dn_evt;
    end
  end

`ifdef COUNT_WRAP_TRACKER_STEP_CHECK_EN
  // Sticky error flag; only clr or rst drop it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign step_err = err_q;
`else
  assign step_err = 1'b0;
`endif

  sat_ctr #(
    .W (WRAP_W)
  ) u_up_ctr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (up_evt),
    .cnt (up_wraps)
  );

  sat_ctr #(
    .W (WRAP_W)
  ) u_dn_ctr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (dn_evt),
    .cnt (dn_wraps)
  );

  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;

endmodule
